mesh_loader: RTL
================

MESH_LOADER -- requirements
Module: mesh_loader

Interface
REQ-001 Parameter ADDR_WIDTH, default 11, RAM word-address width.
REQ-002 Parameter MAX_WORDS, default 2048, largest accepted payload word count; SHALL be <= 2**ADDR_WIDTH.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rstb  input  1  reset, synchronous, active-low.
REQ-005 spi_done  input  1  word-received flag from spi_slave; asynchronous to clk; high at least 3 clk periods per word.
REQ-006 spi_rdata  input  32  received word; stable from spi_done rise until the next word's spi_done rise.
REQ-007 restart  input  1  single-cycle pulse; returns the block from DONE or ERR to IDLE.
REQ-008 ram_en  output  1  RAM enable, quadram port.
REQ-009 ram_we  output  4  RAM byte write enables.
REQ-010 ram_addr  output  ADDR_WIDTH  RAM word address.
REQ-011 ram_di  output  32  RAM write data.
REQ-012 word_count  output  32  payload word count from the header word.
REQ-013 load_done  output  1  level; payload fully written.
REQ-014 overflow  output  1  level; header count exceeded MAX_WORDS.
REQ-015 busy  output  1  level; high in LOAD.

Function
REQ-016 spi_done SHALL pass through a 2-flop synchronizer and then a previous-value flop; word event = sync2 & ~prev, lasting exactly one cycle per spi_done rise.
REQ-017 spi_rdata SHALL be captured into a 32-bit holding register in the cycle the word event is high.
REQ-018 States: IDLE, LOAD, DONE, ERR.
REQ-019 IDLE: first word event takes the header; captured word goes to word_count; next state LOAD if 0 < count <= MAX_WORDS, DONE if count == 0, ERR if count > MAX_WORDS (32-bit unsigned compare).
REQ-020 LOAD: each word event SHALL produce exactly one write cycle on the following clock: ram_en=1, ram_we=4'hF, ram_di=captured word, ram_addr=write index.
REQ-021 Write index SHALL reset to 0 on entry to LOAD and increment by 1 after each write; the first payload word goes to address 0 and word k to address k-1.
REQ-022 Latency: first clk edge sampling spi_done high -> write cycle active 3 cycles later.
REQ-023 After the write to address word_count-1, next state is DONE; load_done SHALL rise in the cycle after that write.
REQ-024 Outside write cycles: ram_we=4'h0, ram_en=0, ram_di=0, ram_addr holds the last written address.
REQ-025 DONE: load_done=1; word events ignored with no RAM writes; word_count held.
REQ-026 ERR: overflow=1; word events ignored with no RAM writes.
REQ-027 restart in DONE or ERR -> IDLE next cycle; load_done and overflow clear; word_count holds until the next header.
REQ-028 restart in IDLE or LOAD has no effect.
REQ-029 restart and a word event in the same cycle in DONE/ERR: restart wins and the word is dropped (not taken as a header).
REQ-030 Write index SHALL never exceed MAX_WORDS-1; no write occurs at an address >= word_count.
REQ-031 busy = (state == LOAD).

Reset
REQ-032 rstb low at a clk edge -> next cycle: state IDLE, write index 0, word_count 0, synchronizer/prev flops 0, load_done 0, overflow 0, busy 0, ram_en 0, ram_we 0, ram_addr 0, ram_di 0.
REQ-033 Reset during LOAD aborts the load; the partial RAM contents are left as written; the next word after reset release is treated as a header.
REQ-034 If spi_done is already high at reset release, no word event is generated until spi_done falls and rises again; prev seeded from sync2 on the first post-reset cycle.

Verification
REQ-035 Header 3, words A0000001/A0000002/A0000003 -> writes to addresses 0,1,2, each 3 cycles after its spi_done rise; load_done=1; word_count=3.
REQ-036 Header 0 -> DONE next cycle, load_done=1, zero RAM writes; a following word -> no write.
REQ-037 Header 2049 (MAX_WORDS=2048) -> overflow=1, no writes; restart pulse -> IDLE; header 1 + word 5 -> write 5 at addr 0.
REQ-038 rstb low after 2 of 4 payload words -> outputs at reset values; next word treated as a header.
REQ-039 In DONE, restart coincident with a word event -> IDLE, the word is not taken as a header; the next word is.
REQ-040 spi_done held high across reset release -> no write and no header until a fresh rise.

Source files
------------

// File: rtl/mesh_loader.sv
// Loads a SPI-delivered mesh image into RAM: the first word is a payload count,
// the following words are written to consecutive RAM addresses starting at 0.
module mesh_loader #(
  parameter int ADDR_WIDTH = 11,
  parameter int MAX_WORDS  = 2048
) (
  input  logic                  i_clk,
  input  logic                  i_rstb,
  input  logic                  i_spi_done,
  input  logic [31:0]           i_spi_rdata,
  input  logic                  i_restart,
  output logic                  o_ram_en,
  output logic [3:0]            o_ram_we,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic [31:0]           o_ram_di,
  output logic [31:0]           o_word_count,
  output logic                  o_load_done,
  output logic                  o_overflow,
  output logic                  o_busy,
  output logic [1:0]            o_state
);

  // Handshake: i_spi_done is a level flag from another clock domain; each rising
  // edge (after synchronization) is one word, and i_spi_rdata is stable from that
  // rise until the next rise. There is no back-pressure: every word is consumed.

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE, S_ERR} state_t;

  localparam logic [31:0] MAX_W = 32'(MAX_WORDS);

  state_t                r_state;
  logic                  r_sync1;
  logic                  r_sync2;
  logic                  r_prev;
  logic                  r_armed;
  logic [1:0]            r_settle;
  logic [31:0]           r_hold;
  logic                  r_pend;
  logic                  r_fin;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic [31:0]           r_word_count;
  logic                  r_ram_en;
  logic [3:0]            r_ram_we;
  logic [ADDR_WIDTH-1:0] r_ram_addr;
  logic [31:0]           r_ram_di;
  logic                  r_load_done;
  logic                  r_overflow;

  logic                  w_evt;
  logic                  w_last;

  // r_armed stays low until the synchronizer has settled and seen spi_done low,
  // so a level already high at reset release never counts as a word.
  assign w_evt  = r_sync2 & ~r_prev & r_armed;
  assign w_last = (32'(r_idx) == (r_word_count - 32'd1));

  always_ff @(posedge i_clk) begin
    if (!i_rstb) begin
      r_state      <= S_IDLE;
      r_sync1      <= 1'b0;
      r_sync2      <= 1'b0;
      r_prev       <= 1'b0;
      r_armed      <= 1'b0;
      r_settle     <= 2'd0;
      r_hold       <= 32'd0;
      r_pend       <= 1'b0;
      r_fin        <= 1'b0;
      r_idx        <= '0;
      r_word_count <= 32'd0;
      r_ram_en     <= 1'b0;
      r_ram_we     <= 4'h0;
      r_ram_addr   <= '0;
      r_ram_di     <= 32'd0;
      r_load_done  <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_sync1 <= i_spi_done;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      if (r_settle != 2'd2) r_settle <= r_settle + 2'd1;
      else if (!r_sync2)    r_armed  <= 1'b1;

      r_ram_en <= 1'b0;
      r_ram_we <= 4'h0;
      r_ram_di <= 32'd0;
      r_pend   <= 1'b0;
      if (w_evt) r_hold <= i_spi_rdata;

      case (r_state)
        S_IDLE: begin
          if (w_evt) begin
            r_word_count <= i_spi_rdata;
            if (i_spi_rdata == 32'd0) begin
              r_state     <= S_DONE;
              r_load_done <= 1'b1;
            end else if (i_spi_rdata > MAX_W) begin
              r_state    <= S_ERR;
              r_overflow <= 1'b1;
            end else begin
              r_state <= S_LOAD;
              r_idx   <= '0;
            end
          end
        end
        S_LOAD: begin
          if (w_evt && !r_fin) r_pend <= 1'b1;
          if (r_pend) begin
            r_ram_en   <= 1'b1;
            r_ram_we   <= 4'hF;
            r_ram_di   <= r_hold;
            r_ram_addr <= r_idx;
            if (w_last) r_fin <= 1'b1;
            else        r_idx <= r_idx + 1'b1;
          end
          if (r_fin) begin
            r_fin       <= 1'b0;
            r_state     <= S_DONE;
            r_load_done <= 1'b1;
          end
        end
        S_DONE, S_ERR: begin
          if (i_restart) begin
            r_state     <= S_IDLE;
            r_load_done <= 1'b0;
            r_overflow  <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_ram_en     = r_ram_en;
  assign o_ram_we     = r_ram_we;
  assign o_ram_addr   = r_ram_addr;
  assign o_ram_di     = r_ram_di;
  assign o_word_count = r_word_count;
  assign o_load_done  = r_load_done;
  assign o_overflow   = r_overflow;
  assign o_busy       = (r_state == S_LOAD);
  assign o_state      = r_state;

endmodule
